// File: rtl/sensor_edge_capture.sv
// sensor_edge_capture: qualifies edges of the debounced home/limit sensor, latches encoder position, counts edges.
// Latency: an edge in cycle N is registered at the end of cycle N; event outputs are visible from cycle N+1.
// Backpressure: none; a held event blocks new captures until cleared, and further edges only set overrun.
module sensor_edge_capture #(
  parameter int POS_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 sensor_state,
  input  logic [POS_WIDTH-1:0] encoder_pos,
  input  logic                 capture_enable,
  input  logic [1:0]           edge_mode,
  input  logic                 event_clear,
  output logic                 event_valid,
  output logic                 event_edge,
  output logic [POS_WIDTH-1:0] event_pos,
  output logic                 event_overrun,
  output logic [CNT_WIDTH-1:0] event_count,
  output logic [1:0]           cap_state
);

  typedef enum logic [1:0] {
    DISARMED = 2'b00,
    ARMED    = 2'b01,
    HELD     = 2'b10
  } cap_state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  cap_state_t           state;
  logic                 sensor_prev;
  logic                 rise;
  logic                 fall;
  logic                 qual;
  logic [CNT_WIDTH-1:0] count_next;

  // Edge detect against last cycle's sensor level; edge_mode acts without a pipeline stage.
  always_comb begin
    rise       = sensor_state & ~sensor_prev;
    fall       = ~sensor_state & sensor_prev;
    qual       = (edge_mode[0] & rise) | (edge_mode[1] & fall);
    count_next = (event_count == CNT_MAX) ? event_count : event_count + CNT_ONE;
  end

  assign cap_state = state;

  // Capture FSM with registered event outputs; sensor_prev tracks the sensor even in reset.
  always_ff @(posedge sys_clk) begin
    sensor_prev <= sensor_state;
    if (sys_rst) begin
      state         <= DISARMED;
      event_valid   <= 1'b0;
      event_edge    <= 1'b0;
      event_pos     <= '0;
      event_overrun <= 1'b0;
      event_count   <= '0;
    end else begin
      case (state)
        DISARMED: begin
          if (capture_enable) begin
            state <= ARMED;
          end
        end
        ARMED: begin
          // Disarm takes priority over a coincident edge.
          if (!capture_enable) begin
            state <= DISARMED;
          end else if (qual) begin
            state       <= HELD;
            event_valid <= 1'b1;
            event_edge  <= rise;
            event_pos   <= encoder_pos;
            event_count <= count_next;
          end
        end
        HELD: begin
          // Only event_clear leaves HELD; capture_enable=0 keeps the event.
          if (event_clear && qual) begin
            // Clear and new edge together: the new edge replaces the old event.
            event_valid   <= 1'b1;
            event_edge    <= rise;
            event_pos     <= encoder_pos;
            event_overrun <= 1'b0;
            event_count   <= count_next;
          end else if (event_clear) begin
            event_valid   <= 1'b0;
            event_overrun <= 1'b0;
            state         <= capture_enable ? ARMED : DISARMED;
          end else if (qual) begin
            event_overrun <= 1'b1;
            event_count   <= count_next;
          end
        end
        default: begin
          state <= DISARMED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_edge_capture.sv
// tb_sensor_edge_capture: drives sensor edges and checks captured events, overrun, counter and FSM state.
// Latency: outputs sampled 1 ns after the rising edge that registers them.
// Backpressure: none in the design; the bench only schedules clears.
module tb_sensor_edge_capture;

  localparam int POS_WIDTH = 32;
  localparam int CNT_WIDTH = 4;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst;
  logic                 sensor_state;
  logic [POS_WIDTH-1:0] encoder_pos;
  logic                 capture_enable;
  logic [1:0]           edge_mode;
  logic                 event_clear;
  logic                 event_valid;
  logic                 event_edge;
  logic [POS_WIDTH-1:0] event_pos;
  logic                 event_overrun;
  logic [CNT_WIDTH-1:0] event_count;
  logic [1:0]           cap_state;

  typedef struct {
    logic                 rising;
    logic [POS_WIDTH-1:0] pos;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_cnt = 0;

  sensor_edge_capture #(.POS_WIDTH(POS_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .sensor_state   (sensor_state),
    .encoder_pos    (encoder_pos),
    .capture_enable (capture_enable),
    .edge_mode      (edge_mode),
    .event_clear    (event_clear),
    .event_valid    (event_valid),
    .event_edge     (event_edge),
    .event_pos      (event_pos),
    .event_overrun  (event_overrun),
    .event_count    (event_count),
    .cap_state      (cap_state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Pop the oldest expected capture and compare against the held event.
  task automatic pop_and_check(input string tag);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s scoreboard empty when event observed", tag);
      return;
    end
    e = sb.pop_front();
    if (event_valid !== 1'b1 || event_edge !== e.rising || event_pos !== e.pos) begin
      fails++;
      $display("FAIL %s event got valid=%b edge=%b pos=%h expected valid=1 edge=%b pos=%h",
               tag, event_valid, event_edge, event_pos, e.rising, e.pos);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; sensor_state = 1'b1; encoder_pos = 32'hDEAD_BEEF;
    capture_enable = 1'b0; edge_mode = 2'b01; event_clear = 1'b0;
    tick(); tick();
    sys_rst = 1'b0;
    tick();
    tests++;
    if (event_valid !== 1'b0 || event_edge !== 1'b0 || event_pos !== '0 || event_overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs got v=%b e=%b p=%h o=%b expected all zero",
               event_valid, event_edge, event_pos, event_overrun);
    end
    tests++;
    if (event_count !== 4'd0 || cap_state !== 2'b00) begin
      fails++;
      $display("FAIL reset_state got cnt=%0d st=%b expected cnt=0 st=00", event_count, cap_state);
    end
    capture_enable = 1'b1;
    tick(); tick(); tick();
    tests++;
    if (cap_state !== 2'b01 || event_valid !== 1'b0 || event_count !== 4'd0) begin
      fails++;
      $display("FAIL arm_no_false_edge got st=%b v=%b cnt=%0d expected st=01 v=0 cnt=0",
               cap_state, event_valid, event_count);
    end
  endtask

  task automatic test_capture();
    sensor_state = 1'b0;              // falling edge, not qualified in mode 01
    tick();
    tests++;
    if (event_valid !== 1'b0 || event_count !== 4'd0) begin
      fails++;
      $display("FAIL fall_ignored got v=%b cnt=%0d expected v=0 cnt=0", event_valid, event_count);
    end
    encoder_pos = 32'h0000_1234; sensor_state = 1'b1;
    sb.push_back('{rising: 1'b1, pos: 32'h0000_1234});
    exp_cnt++;
    tick();
    encoder_pos = 32'h0000_5678;
    pop_and_check("capture_rise");
    tests++;
    if (event_count !== 4'(exp_cnt) || cap_state !== 2'b10 || event_overrun !== 1'b0) begin
      fails++;
      $display("FAIL capture_status got cnt=%0d st=%b o=%b expected cnt=%0d st=10 o=0",
               event_count, cap_state, event_overrun, exp_cnt);
    end
  endtask

  task automatic test_overrun();
    edge_mode = 2'b11;
    encoder_pos = 32'h0000_9999; sensor_state = 1'b0; exp_cnt++;
    tick();
    encoder_pos = 32'h0000_AAAA; sensor_state = 1'b1; exp_cnt++;
    tick();
    tests++;
    if (event_pos !== 32'h0000_1234 || event_edge !== 1'b1 || event_valid !== 1'b1) begin
      fails++;
      $display("FAIL overrun_keep got p=%h e=%b v=%b expected p=00001234 e=1 v=1",
               event_pos, event_edge, event_valid);
    end
    tests++;
    if (event_overrun !== 1'b1 || event_count !== 4'(exp_cnt)) begin
      fails++;
      $display("FAIL overrun_flag got o=%b cnt=%0d expected o=1 cnt=%0d", event_overrun, event_count, exp_cnt);
    end
    event_clear = 1'b1;
    tick();
    event_clear = 1'b0;
    tests++;
    if (event_valid !== 1'b0 || event_overrun !== 1'b0 || cap_state !== 2'b01 || event_count !== 4'(exp_cnt)) begin
      fails++;
      $display("FAIL clear got v=%b o=%b st=%b cnt=%0d expected v=0 o=0 st=01 cnt=%0d",
               event_valid, event_overrun, cap_state, event_count, exp_cnt);
    end
  endtask

  task automatic test_clear_and_edge();
    edge_mode = 2'b01;
    sensor_state = 1'b0;
    tick();
    encoder_pos = 32'h0000_0077; sensor_state = 1'b1;
    sb.push_back('{rising: 1'b1, pos: 32'h0000_0077});
    exp_cnt++;
    tick();
    pop_and_check("capture_second");
    edge_mode = 2'b10;
    encoder_pos = 32'h0000_0055; sensor_state = 1'b0; event_clear = 1'b1;
    sb.push_back('{rising: 1'b0, pos: 32'h0000_0055});
    exp_cnt++;
    tick();
    event_clear = 1'b0;
    pop_and_check("clear_with_edge");
    tests++;
    if (event_overrun !== 1'b0 || cap_state !== 2'b10 || event_count !== 4'(exp_cnt)) begin
      fails++;
      $display("FAIL clear_with_edge_status got o=%b st=%b cnt=%0d expected o=0 st=10 cnt=%0d",
               event_overrun, cap_state, event_count, exp_cnt);
    end
    event_clear = 1'b1;
    tick();
    event_clear = 1'b0;
    tests++;
    if (event_valid !== 1'b0 || cap_state !== 2'b01) begin
      fails++;
      $display("FAIL rearm got v=%b st=%b expected v=0 st=01", event_valid, cap_state);
    end
  endtask

  task automatic test_saturation();
    edge_mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      sensor_state = ~sensor_state;
      tick();
    end
    tests++;
    if (event_count !== 4'(exp_cnt) || event_valid !== 1'b0) begin
      fails++;
      $display("FAIL mode00_ignored got cnt=%0d v=%b expected cnt=%0d v=0", event_count, event_valid, exp_cnt);
    end
    edge_mode = 2'b11;
    for (int i = 0; i < 20; i++) begin
      sensor_state = ~sensor_state;
      encoder_pos  = 32'(i);
      event_clear  = (i % 3 == 2);
      if (exp_cnt < 15) exp_cnt++;
      tick();
      event_clear = 1'b0;
      tests++;
      if (event_count !== 4'(exp_cnt)) begin
        fails++;
        $display("FAIL sat_step%0d got cnt=%0d expected %0d", i, event_count, exp_cnt);
      end
    end
    tests++;
    if (event_count !== 4'd15 || event_valid !== 1'b1) begin
      fails++;
      $display("FAIL saturated got cnt=%0d v=%b expected cnt=15 v=1", event_count, event_valid);
    end
  endtask

  task automatic test_reset_held();
    tests++;
    if (cap_state !== 2'b10) begin
      fails++;
      $display("FAIL pre_reset_held got st=%b expected 10", cap_state);
    end
    sys_rst = 1'b1; sensor_state = ~sensor_state;
    tick();
    tests++;
    if (event_valid !== 1'b0 || event_edge !== 1'b0 || event_pos !== '0 || event_overrun !== 1'b0 ||
        event_count !== 4'd0 || cap_state !== 2'b00) begin
      fails++;
      $display("FAIL reset_held got v=%b e=%b p=%h o=%b cnt=%0d st=%b expected all zero",
               event_valid, event_edge, event_pos, event_overrun, event_count, cap_state);
    end
    sys_rst = 1'b0;
    tick(); tick();
    tests++;
    if (event_valid !== 1'b0 || event_count !== 4'd0 || sb.size() != 0) begin
      fails++;
      $display("FAIL post_reset got v=%b cnt=%0d sb=%0d expected v=0 cnt=0 sb=0",
               event_valid, event_count, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_overrun();
    test_clear_and_edge();
    test_saturation();
    test_reset_held();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
